// File: rtl/port_rx.sv
// Ingress port: validates packet headers, buffers bytes store-and-forward, releases only whole packets.
// Optional statistics counters are built when PORT_RX_STATS_EN is defined.
module port_rx #(
  parameter int DEPTH   = 32,
  parameter int PORT_ID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic [7:0]  out_data,
  output logic [3:0]  out_target,
  input  logic        out_ready,
  output logic        drop_pulse,
  output logic [15:0] rx_pkt_cnt,
  output logic [15:0] rx_drop_cnt,
  output logic [1:0]  dbg_state
);
  // Handshake: a byte moves only on a cycle where valid and ready are both high.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, BODY = 2'd1, DROP = 2'd2} state_e;

  state_e        state_q;
  logic [PW-1:0] wr_ptr_q, commit_ptr_q, rd_ptr_q;
  logic [4:0]    len_q;
  logic          drop_pulse_q;
  logic          out_valid_q, out_sop_q, out_eop_q, next_sop_q;
  logic [7:0]    out_data_q;
  logic [3:0]    out_target_q;
  logic [8:0]    mem_q [DEPTH];

  logic          accept, hdr_ok, over_len, commit_now, full, load;
  logic          hdr_wr, body_wr, wr_en;
  logic [PW-1:0] wr_addr, avail_ptr, used;
  logic [8:0]    rd_word;

  assign accept     = in_valid && in_ready;
  assign hdr_ok     = in_sop && !in_eop && (in_data[7:4] != 4'b0000) && !in_data[4+PORT_ID];
  assign over_len   = (len_q == 5'd16);
  assign commit_now = accept && (state_q == BODY) && !in_sop && !over_len && in_eop;

  // The byte held in the output register still owns its slot until it is taken.
  assign used     = wr_ptr_q - rd_ptr_q + {{(PW-1){1'b0}}, out_valid_q};
  assign full     = (used == PW'(DEPTH));
  assign in_ready = rst_n && ((state_q == DROP) || !full);

  // In IDLE/DROP wr_ptr equals commit_ptr, so a header always lands at commit_ptr.
  assign hdr_wr  = accept && hdr_ok && (state_q != DROP);
  assign body_wr = accept && (state_q == BODY) && !in_sop && !over_len;
  assign wr_en   = hdr_wr || body_wr;
  assign wr_addr = hdr_wr ? commit_ptr_q : wr_ptr_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr[AW-1:0]] <= {in_eop, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      len_q        <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= 1'b0;
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (!in_sop) begin
              drop_pulse_q <= 1'b1;
            end else if (hdr_ok) begin
              wr_ptr_q <= commit_ptr_q + PTR_ONE;
              len_q    <= 5'd1;
              state_q  <= BODY;
            end else begin
              drop_pulse_q <= 1'b1;
              state_q      <= in_eop ? IDLE : DROP;
            end
          end
          BODY: begin
            if (in_sop) begin
              // Abandon the open packet and restart on this header in the same beat.
              drop_pulse_q <= 1'b1;
              if (hdr_ok) begin
                wr_ptr_q <= commit_ptr_q + PTR_ONE;
                len_q    <= 5'd1;
              end else begin
                wr_ptr_q <= commit_ptr_q;
                state_q  <= in_eop ? IDLE : DROP;
              end
            end else if (over_len) begin
              drop_pulse_q <= 1'b1;
              wr_ptr_q     <= commit_ptr_q;
              state_q      <= in_eop ? IDLE : DROP;
            end else begin
              wr_ptr_q <= wr_ptr_q + PTR_ONE;
              len_q    <= len_q + 5'd1;
              if (in_eop) begin
                commit_ptr_q <= wr_ptr_q + PTR_ONE;
                state_q      <= IDLE;
              end
            end
          end
          DROP: begin
            if (in_eop) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Egress sees a commit in the same cycle it happens, so sop appears one cycle after eop.
  assign avail_ptr = commit_now ? (wr_ptr_q + PTR_ONE) : commit_ptr_q;
  assign load      = (!out_valid_q || out_ready) && (rd_ptr_q != avail_ptr);
  assign rd_word   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_data_q   <= 8'h00;
      out_target_q <= 4'h0;
      next_sop_q   <= 1'b1;
    end else if (load) begin
      rd_ptr_q    <= rd_ptr_q + PTR_ONE;
      out_valid_q <= 1'b1;
      out_sop_q   <= next_sop_q;
      out_eop_q   <= rd_word[8];
      out_data_q  <= rd_word[7:0];
      next_sop_q  <= rd_word[8];
      if (next_sop_q) out_target_q <= rd_word[7:4];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef PORT_RX_STATS_EN
  logic [15:0] pkt_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= 16'h0000;
      drop_cnt_q <= 16'h0000;
    end else begin
      if (commit_now && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (drop_pulse_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign rx_pkt_cnt  = pkt_cnt_q;
  assign rx_drop_cnt = drop_cnt_q;
`else
  assign rx_pkt_cnt  = 16'h0000;
  assign rx_drop_cnt = 16'h0000;
`endif

  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign out_data   = out_data_q;
  assign out_target = out_target_q;
  assign drop_pulse = drop_pulse_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_port_rx.sv
// Bench for port_rx: header-legality vector table, scoreboarded egress, and hand-written
// sequences for mid-packet sop, over-length, full FIFO back-to-back egress and reset.
module tb_port_rx;
`ifdef PORT_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_sop, out_eop, drop_pulse;
  logic [7:0]  out_data;
  logic [3:0]  out_target;
  logic [15:0] rx_pkt_cnt, rx_drop_cnt;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  port_rx #(.DEPTH(32), .PORT_ID(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_target(out_target), .out_ready(out_ready),
    .drop_pulse(drop_pulse), .rx_pkt_cnt(rx_pkt_cnt), .rx_drop_cnt(rx_drop_cnt),
    .dbg_state(dbg_state)
  );

  // Expected egress beat: {target, sop, eop, data}
  logic [13:0] exp_q[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, beats = 0, drops = 0, sop_cyc = -1, last_beat_cyc = 0, acc_cyc = 0;
  int exp_pkts = 0, exp_drops = 0;
  logic        stalled_prev = 1'b0;
  logic [13:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: samples on the falling edge, scoreboard pop on every egress transfer.
  always @(negedge clk) begin
    logic [13:0] got, e;
    if (rst_n) begin
      if (drop_pulse) drops++;
      got = {out_target, out_sop, out_eop, out_data};
      if (out_valid) begin
        if (stalled_prev) chk("stall_hold", got, held);
        if (out_ready) begin
          chk("egress_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("egress_beat", got, e);
          end
          beats++;
          if (out_sop) sop_cyc = cyc;
          last_beat_cyc = cyc;
          stalled_prev = 1'b0;
        end else begin
          stalled_prev = 1'b1;
          held = got;
        end
      end else begin
        stalled_prev = 1'b0;
      end
    end else begin
      stalled_prev = 1'b0;
    end
    cyc++;
  end

  task automatic send_beat(input logic s, input logic e, input logic [7:0] d);
    int n = 0;
    logic got = 1'b0;
    in_valid = 1'b1; in_sop = s; in_eop = e; in_data = d;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      n++;
    end
    acc_cyc = cyc;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!got) chk("send_accept_timeout", got, 1);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int len, input bit legal);
    logic [7:0] b[32];
    b[0] = hdr;
    for (int i = 1; i < len; i++) b[i] = 8'($urandom_range(0, 255));
    if (legal) begin
      for (int i = 0; i < len; i++) exp_q.push_back({hdr[7:4], i == 0, i == len - 1, b[i]});
      exp_pkts++;
    end
    for (int i = 0; i < len; i++) send_beat(i == 0, i == len - 1, b[i]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_pkt_cnt"}, rx_pkt_cnt, STATS ? exp_pkts : 0);
    chk({tag, "_drop_cnt"}, rx_drop_cnt, STATS ? exp_drops : 0);
  endtask

  typedef struct {
    logic [7:0] hdr;
    logic       one_beat;
    logic       legal;
  } hdr_vec_t;

  hdr_vec_t vecs[8];

  initial begin
    int d0, b0, c0, n;
    vecs[0] = '{hdr: 8'h24, one_beat: 1'b0, legal: 1'b1};
    vecs[1] = '{hdr: 8'h10, one_beat: 1'b0, legal: 1'b0};
    vecs[2] = '{hdr: 8'h04, one_beat: 1'b0, legal: 1'b0};
    vecs[3] = '{hdr: 8'h80, one_beat: 1'b0, legal: 1'b1};
    vecs[4] = '{hdr: 8'hE8, one_beat: 1'b0, legal: 1'b1};
    vecs[5] = '{hdr: 8'h1F, one_beat: 1'b0, legal: 1'b0};
    vecs[6] = '{hdr: 8'h24, one_beat: 1'b1, legal: 1'b0};
    vecs[7] = '{hdr: 8'hF0, one_beat: 1'b0, legal: 1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_drop_pulse", drop_pulse, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_target", out_target, 0);
    chk("rst_state", dbg_state, 0);
    chk_stats("rst");
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_release", in_ready, 1);
    @(posedge clk); #1;

    // Basic packet, sop must appear the cycle right after the eop transfer
    d0 = drops;
    exp_q.push_back({4'b0010, 1'b1, 1'b0, 8'h24});
    exp_q.push_back({4'b0010, 1'b0, 1'b0, 8'h11});
    exp_q.push_back({4'b0010, 1'b0, 1'b0, 8'h22});
    exp_q.push_back({4'b0010, 1'b0, 1'b1, 8'h33});
    exp_pkts++;
    send_beat(1'b1, 1'b0, 8'h24);
    send_beat(1'b0, 1'b0, 8'h11);
    send_beat(1'b0, 1'b0, 8'h22);
    send_beat(1'b0, 1'b1, 8'h33);
    wait_drain();
    chk("sop_latency", sop_cyc, acc_cyc);
    chk("basic_no_drop", drops - d0, 0);
    chk_stats("basic");

    // Header legality table
    for (int v = 0; v < 8; v++) begin
      d0 = drops;
      if (vecs[v].one_beat) send_beat(1'b1, 1'b1, vecs[v].hdr);
      else send_pkt(vecs[v].hdr, $urandom_range(2, 5), vecs[v].legal);
      wait_drain();
      chk($sformatf("vec%0d_drops", v), drops - d0, vecs[v].legal ? 0 : 1);
      if (!vecs[v].legal) exp_drops++;
      chk($sformatf("vec%0d_in_ready", v), in_ready, 1);
    end
    chk_stats("table");

    // Stray byte in IDLE
    d0 = drops;
    send_beat(1'b0, 1'b0, 8'h5A);
    wait_drain();
    chk("stray_drop", drops - d0, 1);
    exp_drops++;

    // Mid-packet sop: A is abandoned, B egresses intact
    d0 = drops;
    send_beat(1'b1, 1'b0, 8'h24);
    send_beat(1'b0, 1'b0, 8'hA1);
    send_beat(1'b0, 1'b0, 8'hA2);
    send_pkt(8'h80, 3, 1'b1);
    wait_drain();
    chk("midsop_drops", drops - d0, 1);
    exp_drops++;

    // Over-length packet dropped, next packet unaffected
    d0 = drops;
    send_pkt(8'h24, 17, 1'b0);
    send_pkt(8'h44, 5, 1'b1);
    wait_drain();
    chk("overlen_drops", drops - d0, 1);
    exp_drops++;
    chk_stats("mid");

    // Fill the FIFO with egress stalled, then drain back-to-back
    out_ready = 1'b0;
    send_pkt(8'h28, 16, 1'b1);
    send_pkt(8'h48, 16, 1'b1);
    in_valid = 1'b1; in_sop = 1'b1; in_data = 8'h24;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("in_ready_full", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0;
    b0 = beats;
    c0 = cyc;
    out_ready = 1'b1;
    n = 0;
    while (beats < b0 + 32 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_beats", beats - b0, 32);
    chk("b2b_span", last_beat_cyc - c0, 31);
    wait_drain();

    // Reset while a packet is egressing and another is arriving
    send_pkt(8'h80, 8, 1'b1);
    send_beat(1'b1, 1'b0, 8'h24);
    send_beat(1'b0, 1'b0, 8'h01);
    chk("pre_reset_egress_busy", out_valid, 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_pkts = 0;
    exp_drops = 0;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_data", out_data, 0);
    chk("rst_mid_out_target", out_target, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    chk("rst_mid_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst2", in_ready, 1);
    @(posedge clk); #1;
    b0 = beats;
    send_pkt(8'h24, 3, 1'b1);
    wait_drain();
    chk("post_reset_beats", beats - b0, 3);
    chk_stats("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
